sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_mem_pkg.sv | 25 ++
 rtl/sram_wait_counter.sv | 33 +++
 rtl/sram_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// ============================================================================
// Module : arm_mem_pkg
// Brief  : Shared FSM state type, base address and SRAM bus widths for the
//          CPU-to-SRAM memory path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arm_mem_pkg;

   localparam int          c_sram_addr_w       = 18;
   localparam int          c_sram_data_w       = 16;
   localparam int          c_word_index_w      = c_sram_addr_w - 1;
   localparam int unsigned c_base_addr_default = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module : sram_wait_counter
// Brief  : Per-phase wait counter; counts 0..WAIT_CYCLES-1 with clear and
//          enable, flagging the final count of a phase.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_wait_counter #(
   parameter int WAIT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   logic [3:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= 4'd0;
      end else if (i_enable) begin
         r_count <= r_count + 4'd1;
      end
   end

   assign o_terminal = (r_count == 4'(WAIT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module : sram_controller
// Brief  : Splits 32-bit CPU loads/stores into two timed 16-bit SRAM phases
//          and holds the pipeline off via ready until the access completes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_controller
   import arm_mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = c_base_addr_default,
   parameter int          WAIT_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [31:0]              address,
   input  logic [31:0]              write_data,
   output logic [31:0]              read_data,
   output logic                     ready,
   output logic [c_sram_addr_w-1:0] sram_addr,
   output logic [c_sram_data_w-1:0] sram_dq_out,
   output logic                     sram_dq_oe,
   input  logic [c_sram_data_w-1:0] sram_dq_in,
   output logic                     sram_we_n
);

   state_t                    r_state;
   state_t                    w_next_state;
   logic                      r_is_write;
   logic [31:0]               r_read_data;
   logic                      w_request;
   logic                      w_in_phase;
   logic                      w_terminal;
   logic                      w_counter_clear;
   logic [c_word_index_w-1:0] w_index;

   assign w_request       = wr_en | rd_en;
   assign w_in_phase      = (r_state == ST_LO) || (r_state == ST_HI);
   assign w_counter_clear = !w_in_phase || w_terminal;
   assign w_index         = c_word_index_w'((address - BASE_ADDR) >> 2);

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_counter_clear),
      .i_enable   (w_in_phase),
      .o_terminal (w_terminal)
   );

   // Write wins when both requests arrive together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_is_write <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_IDLE && w_request) begin
            r_is_write <= wr_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_read_data <= 32'd0;
      end else if (w_in_phase && !r_is_write && w_terminal) begin
         if (r_state == ST_LO) begin
            r_read_data[15:0] <= sram_dq_in;
         end else begin
            r_read_data[31:16] <= sram_dq_in;
         end
      end
   end

   assign read_data = r_read_data;

   always_comb begin
      w_next_state = r_state;
      ready        = 1'b0;
      sram_addr    = '0;
      sram_dq_out  = '0;
      sram_dq_oe   = 1'b0;
      sram_we_n    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            ready = !w_request;
            if (w_request) begin
               w_next_state = ST_LO;
            end
         end
         ST_LO, ST_HI: begin
            if (w_terminal) begin
               w_next_state = (r_state == ST_LO) ? ST_HI : ST_DONE;
            end
            sram_addr = {w_index, (r_state == ST_HI)};
            if (r_is_write) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = (r_state == ST_LO) ? write_data[15:0] : write_data[31:16];
               // Strobe released on the last cycle so address/data hold past WE rise.
               sram_we_n   = w_terminal;
            end
         end
         ST_DONE: begin
            ready        = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire
